// File: rtl/spawn_pkg.sv
// Shared encodings, default parameters and helpers for the spawn scheduler.
package spawn_pkg;

   localparam int unsigned DEF_RANGE     = 20;
   localparam int unsigned DEF_MIN_GAP   = 30;
   localparam logic [7:0]  DEF_GAP_MASK  = 8'h0F;
   localparam int unsigned DEF_MAX_RETRY = 4;
   localparam int unsigned TIMER_W       = 9;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DRAW_LANE = 3'd1;
   localparam logic [2:0] ST_DRAW_GAP  = 3'd2;
   localparam logic [2:0] ST_WAIT      = 3'd3;
   localparam logic [2:0] ST_OFFER     = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_DRAW_LANE = ST_DRAW_LANE,
      S_DRAW_GAP  = ST_DRAW_GAP,
      S_WAIT      = ST_WAIT,
      S_OFFER     = ST_OFFER
   } state_e;

   // Gap length: minimum plus masked random bits, kept at full timer width.
   function automatic logic [TIMER_W-1:0] gap_len(input logic [7:0] rnd,
                                                  input int unsigned min_gap,
                                                  input logic [7:0] mask);
      return TIMER_W'(min_gap) + TIMER_W'(rnd & mask);
   endfunction

endpackage

// File: rtl/spawn_scheduler_gap_timer.sv
// gap_timer: loadable down-counter; expire_o is high while the count equals one.
module gap_timer
   import spawn_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               expire_o
);

   logic [TIMER_W-1:0] count_q, count_d;
   logic               expire_q;

   // Next count: load wins over decrement; never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   // Count register with expire flag precomputed from the next count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= '0;
         expire_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         expire_q <= (count_d == TIMER_W'(1));
      end
   end

   assign expire_o = expire_q;

endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: turns LFSR bytes into timed lane spawn offers.
// Optional feature macro: SPAWN_NO_REPEAT_EN (reject a repeat of the last accepted lane).
module spawn_scheduler
   import spawn_pkg::*;
#(
   parameter int unsigned RANGE     = DEF_RANGE,
   parameter int unsigned MIN_GAP   = DEF_MIN_GAP,
   parameter logic [7:0]  GAP_MASK  = DEF_GAP_MASK,
   parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
   localparam int unsigned LANE_W   = $clog2(RANGE)
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [7:0]        rnd_in,
   output logic              rnd_en,
   output logic              spawn_valid,
   input  logic              spawn_ready,
   output logic [LANE_W-1:0] spawn_lane,
   output logic [7:0]        spawn_count,
   output logic [7:0]        fallback_cnt
);

   localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [7:0]          count_q, count_d;
   logic [7:0]          fb_q, fb_d;
   logic                rnd_en_q, valid_q;
   logic                tmr_load, tmr_dec, tmr_expire;

   logic [LANE_W-1:0]   cand;
   logic                cand_reject;
   logic [LANE_W-1:0]   fallback_lane;

`ifdef SPAWN_NO_REPEAT_EN
   logic [LANE_W-1:0]   prev_lane_q, prev_lane_d;
   logic                prev_vld_q, prev_vld_d;
`endif

   assign cand = rnd_in[LANE_W-1:0];

   // Candidate rejection and fallback lane selection.
`ifdef SPAWN_NO_REPEAT_EN
   assign cand_reject   = (9'(cand) >= 9'(RANGE)) || (prev_vld_q && (cand == prev_lane_q));
   assign fallback_lane = (prev_lane_q == '0) ? LANE_W'(1) : '0;
`else
   assign cand_reject   = (9'(cand) >= 9'(RANGE));
   assign fallback_lane = '0;
`endif

   gap_timer u_gap_timer (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (tmr_load),
      .load_val_i (gap_len(rnd_in, MIN_GAP, GAP_MASK)),
      .dec_i      (tmr_dec),
      .expire_o   (tmr_expire)
   );

   // Next-state, draw and handshake bookkeeping.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      retry_d  = retry_q;
      count_d  = count_q;
      fb_d     = fb_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
`ifdef SPAWN_NO_REPEAT_EN
      prev_lane_d = prev_lane_q;
      prev_vld_d  = prev_vld_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (go) state_d = S_DRAW_LANE;
         end
         S_DRAW_LANE: begin
            if (!cand_reject) begin
               lane_d  = cand;
               retry_d = '0;
               state_d = S_DRAW_GAP;
            end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
               lane_d  = fallback_lane;
               retry_d = '0;
               if (fb_q != 8'hFF) fb_d = fb_q + 8'd1;
               state_d = S_DRAW_GAP;
            end else begin
               retry_d = retry_q + RETRY_W'(1);
            end
         end
         S_DRAW_GAP: begin
            tmr_load = 1'b1;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            tmr_dec = 1'b1;
            if (tmr_expire) state_d = S_OFFER;
         end
         S_OFFER: begin
            if (spawn_ready) begin
               count_d = count_q + 8'd1;
               state_d = go ? S_DRAW_LANE : S_IDLE;
`ifdef SPAWN_NO_REPEAT_EN
               prev_lane_d = lane_q;
               prev_vld_d  = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; rnd_en/valid are decoded from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         lane_q   <= '0;
         retry_q  <= '0;
         count_q  <= '0;
         fb_q     <= '0;
         rnd_en_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         retry_q  <= retry_d;
         count_q  <= count_d;
         fb_q     <= fb_d;
         rnd_en_q <= (state_d == S_DRAW_LANE) || (state_d == S_DRAW_GAP);
         valid_q  <= (state_d == S_OFFER);
      end
   end

`ifdef SPAWN_NO_REPEAT_EN
   // Last accepted lane, for repeat rejection.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_lane_q <= '0;
         prev_vld_q  <= 1'b0;
      end else begin
         prev_lane_q <= prev_lane_d;
         prev_vld_q  <= prev_vld_d;
      end
   end
`endif

   assign rnd_en       = rnd_en_q;
   assign spawn_valid  = valid_q;
   assign spawn_lane   = lane_q;
   assign spawn_count  = count_q;
   assign fallback_cnt = fb_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_spawn_scheduler;

   localparam int RANGE     = 20;
   localparam int MIN_GAP   = 30;
   localparam int GAP_MASK  = 15;
   localparam int MAX_RETRY = 4;
   localparam int LANE_W    = $clog2(RANGE);

   localparam int P_IDLE  = 0;
   localparam int P_LANE  = 1;
   localparam int P_GAP   = 2;
   localparam int P_WAIT  = 3;
   localparam int P_OFFER = 4;

   logic              clock;
   logic              reset;
   logic              go;
   logic [7:0]        rnd_in;
   logic              rnd_en;
   logic              spawn_valid;
   logic              spawn_ready;
   logic [LANE_W-1:0] spawn_lane;
   logic [7:0]        spawn_count;
   logic [7:0]        fallback_cnt;

   int n_cmp;
   int n_err;

   // model state
   int m_phase, m_rejects, m_wait_left, m_lane, m_count, m_fb, m_prev;
   bit m_have_prev;
   int e_en, e_vld;

   spawn_scheduler dut (
      .clock        (clock),
      .reset        (reset),
      .go           (go),
      .rnd_in       (rnd_in),
      .rnd_en       (rnd_en),
      .spawn_valid  (spawn_valid),
      .spawn_ready  (spawn_ready),
      .spawn_lane   (spawn_lane),
      .spawn_count  (spawn_count),
      .fallback_cnt (fallback_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: one step per clock edge, from the observable rules.
   task automatic model_step();
      int  cand;
      bit  rej;
      int  fb_lane;
      if (reset) begin
         m_phase = P_IDLE; m_rejects = 0; m_wait_left = 0; m_lane = 0;
         m_count = 0; m_fb = 0; m_prev = 0; m_have_prev = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (go) m_phase = P_LANE;
            P_LANE: begin
               cand    = int'(rnd_in) % (1 << LANE_W);
               rej     = (cand >= RANGE);
               fb_lane = 0;
`ifdef SPAWN_NO_REPEAT_EN
               if (m_have_prev && cand == m_prev) rej = 1;
               fb_lane = (m_prev == 0) ? 1 : 0;
`endif
               if (!rej) begin
                  m_lane = cand; m_rejects = 0; m_phase = P_GAP;
               end else begin
                  m_rejects++;
                  if (m_rejects == MAX_RETRY) begin
                     m_lane = fb_lane; m_rejects = 0; m_phase = P_GAP;
                     if (m_fb < 255) m_fb++;
                  end
               end
            end
            P_GAP: begin
               m_wait_left = MIN_GAP + (int'(rnd_in) & GAP_MASK);
               m_phase = P_WAIT;
            end
            P_WAIT: begin
               m_wait_left--;
               if (m_wait_left == 0) m_phase = P_OFFER;
            end
            default: begin
               if (spawn_ready) begin
                  m_count = (m_count + 1) % 256;
                  m_prev = m_lane; m_have_prev = 1;
                  m_phase = go ? P_LANE : P_IDLE;
               end
            end
         endcase
      end
      e_en  = (m_phase == P_LANE || m_phase == P_GAP) ? 1 : 0;
      e_vld = (m_phase == P_OFFER) ? 1 : 0;
   endtask

   // One clock: advance model at the edge, compare all outputs half a cycle later.
   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
      chk("rnd_en",       int'(rnd_en),       e_en);
      chk("spawn_valid",  int'(spawn_valid),  e_vld);
      chk("spawn_lane",   int'(spawn_lane),   m_lane);
      chk("spawn_count",  int'(spawn_count),  m_count);
      chk("fallback_cnt", int'(fallback_cnt), m_fb);
   endtask

   task automatic draw(input logic [7:0] v);
      rnd_in = v;
      tick();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!spawn_valid && n < 200) begin
         tick();
         n++;
      end
      chk("offer_timeout", int'(spawn_valid), 1);
   endtask

   task automatic accept(input logic go_after);
      spawn_ready = 1'b1;
      go = go_after;
      tick();
      spawn_ready = 1'b0;
   endtask

   task automatic reset_check(input string nm);
      reset = 1'b1;
      tick();
      chk({nm, "_rnd_en"}, int'(rnd_en), 0);
      chk({nm, "_valid"},  int'(spawn_valid), 0);
      chk({nm, "_lane"},   int'(spawn_lane), 0);
      chk({nm, "_count"},  int'(spawn_count), 0);
      chk({nm, "_fb"},     int'(fallback_cnt), 0);
      reset = 1'b0;
      go = 1'b0;
      tick();
      chk({nm, "_idle_en"}, int'(rnd_en), 0);
   endtask

   initial begin
      int n, en_cnt;
      n_cmp = 0; n_err = 0;
      m_phase = P_IDLE; m_rejects = 0; m_wait_left = 0; m_lane = 0;
      m_count = 0; m_fb = 0; m_prev = 0; m_have_prev = 0; e_en = 0; e_vld = 0;
      reset = 1'b1; go = 1'b0; spawn_ready = 1'b0; rnd_in = 8'h00;
      repeat (3) tick();
      reset = 1'b0;

      // go low: generator never advanced
      repeat (6) tick();
      chk("idle_rnd_en", int'(rnd_en), 0);
      chk("reset_count", int'(spawn_count), 0);

      // lane 7, gap 35, offer at cycle 38
      go = 1'b1;
      tick();
      draw(8'h07);
      draw(8'h05);
      wait_valid(n);
      chk("latency", 3 + n, 38);
      chk("lane7", int'(spawn_lane), 7);
      accept(1'b0);
      chk("count1", int'(spawn_count), 1);
      chk("valid_drop", int'(spawn_valid), 0);

`ifdef SPAWN_NO_REPEAT_EN
      // repeat of lane 7 rejected
      go = 1'b1;
      tick();
      draw(8'h07);
      draw(8'h09);
      draw(8'h00);
      chk("norep_lane9", int'(spawn_lane), 9);
      wait_valid(n);
      accept(1'b0);
`endif

      // two rejects then lane 3
      go = 1'b1;
      tick();
      en_cnt = 0;
      en_cnt += int'(rnd_en); draw(8'h1F);
      en_cnt += int'(rnd_en); draw(8'h16);
      en_cnt += int'(rnd_en); draw(8'h03);
      draw(8'h00);
      chk("lane_draw_en_cycles", en_cnt, 3);
      chk("lane3", int'(spawn_lane), 3);
      chk("no_fallback", int'(fallback_cnt), 0);
      wait_valid(n);
      accept(1'b0);

      // persistent rejects -> fallback lane 0
      go = 1'b1;
      tick();
      repeat (4) draw(8'h1F);
      draw(8'h00);
      chk("fallback_lane", int'(spawn_lane), 0);
      chk("fallback_cnt1", int'(fallback_cnt), 1);
      wait_valid(n);
      accept(1'b0);

      // go dropped in WAIT; offer held under backpressure; then idle
      go = 1'b1;
      tick();
      draw(8'h02);
      draw(8'h01);
      go = 1'b0;
      wait_valid(n);
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", int'(spawn_valid), 1);
         chk("hold_lane", int'(spawn_lane), 2);
         tick();
      end
      accept(1'b0);
      chk("drop_after_accept", int'(spawn_valid), 0);
      repeat (5) tick();
      chk("idle_after_offer", int'(rnd_en), 0);

      // reset from each busy state
      go = 1'b1; tick();
      reset_check("rst_lane");
      go = 1'b1; tick(); draw(8'h05);
      reset_check("rst_gap");
      go = 1'b1; tick(); draw(8'h05); draw(8'h00); repeat (4) tick();
      reset_check("rst_wait");
      go = 1'b1; tick(); draw(8'h05); draw(8'h00); wait_valid(n);
      reset_check("rst_offer");

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         go          = ($urandom_range(0, 9) != 0);
         spawn_ready = ($urandom_range(0, 2) != 0);
         rnd_in      = 8'($urandom_range(0, 255));
         reset       = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 1'b0;

      // back-to-back fallbacks: saturation of fallback_cnt and wrap of spawn_count
      reset = 1'b1; tick(); reset = 1'b0;
      go = 1'b1; spawn_ready = 1'b1; rnd_in = 8'h14;
      repeat (11000) tick();
      chk("fb_saturate", int'(fallback_cnt), 255);
      go = 1'b0; spawn_ready = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
